// File: rtl/mul_pkg.sv
// Shared types for the iterative multiplier: opcode and FSM state encodings.
package mul_pkg;

    localparam int MUL_OP_W = 2;

    typedef enum logic [MUL_OP_W-1:0] {
        MUL   = 2'd0,
        MLA   = 2'd1,
        UMULL = 2'd2,
        SMULL = 2'd3
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    // Long ops return a full 2*WIDTH product; the others return one word.
    function automatic logic is_long(mul_op_t op);
        return (op == UMULL) || (op == SMULL);
    endfunction

endpackage

// File: rtl/mul_if.sv
// Request/response bundle between a requester and mul_unit.
interface mul_if #(
    parameter int WIDTH = 32
) ();
    import mul_pkg::*;

    logic             start;
    mul_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acc;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [1:0]       flags;

    modport master (
        output start, op, a, b, acc, flush,
        input  busy, done, result_lo, result_hi, flags
    );

    modport slave (
        input  start, op, a, b, acc, flush,
        output busy, done, result_lo, result_hi, flags
    );

endinterface

// File: rtl/mul_step.sv
// One radix-2^BPC step: add the partial products selected by the low BPC
// multiplier bits to the running 2*WIDTH product.
module mul_step #(
    parameter int WIDTH = 32,
    parameter int BPC   = 2
) (
    input  logic [2*WIDTH-1:0] prod_in,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [BPC-1:0]     mbits,
    output logic [2*WIDTH-1:0] prod_out
);

    logic [BPC-1:0][2*WIDTH-1:0] pp;

    for (genvar i = 0; i < BPC; i++) begin : g_pp
        assign pp[i] = mbits[i] ? (mcand << i) : '0;
    end

    // Sum the selected partial products onto the incoming product
    always_comb begin
        prod_out = prod_in;
        for (int i = 0; i < BPC; i++) begin
            prod_out = prod_out + pp[i];
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier: IDLE -> RUN (BPC bits/cycle) -> FIX -> DONE.
// The bus interface must be instantiated with the same WIDTH as this module.
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BPC        = 2,
    parameter int EARLY_TERM = 1
) (
    input  logic clk,
    input  logic reset,
    mul_if.slave bus
);

    localparam int ITERS = WIDTH / BPC;
    localparam int CNT_W = $clog2(ITERS + 1);

    mul_state_t       state;
    mul_op_t          op_q;
    logic [WIDTH-1:0] acc_q;
    logic             sign_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic [1:0]       flags_q;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] mplier_nxt;
    logic [2*WIDTH-1:0] step_out;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] lo_fix;
    logic [WIDTH-1:0] hi_fix;
    logic [1:0]       flags_fix;

    // A new request is taken only when nothing is in flight and no abort is pending
    assign accept = bus.start && !bus.flush && (state == IDLE || state == DONE);

    // SMULL works on magnitudes; the sign is reapplied in FIX
    always_comb begin
        mag_a = bus.a;
        mag_b = bus.b;
        if (bus.op == SMULL) begin
            if (bus.a[WIDTH-1]) mag_a = -bus.a;
            if (bus.b[WIDTH-1]) mag_b = -bus.b;
        end
    end

    mul_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
        .prod_in  (prod_q),
        .mcand    (mcand_q),
        .mbits    (mplier_q[BPC-1:0]),
        .prod_out (step_out)
    );

    assign mplier_nxt = mplier_q >> BPC;

    // Stop once the remaining multiplier is empty (early term) or all bits are retired
    always_comb begin
        last_iter = (cnt_q == CNT_W'(ITERS - 1));
        if (EARLY_TERM != 0 && mplier_nxt == '0) last_iter = 1'b1;
    end

    // Final fix-up: sign restore, MLA addend, word selection and flags
    always_comb begin
        prod_s = sign_q ? -prod_q : prod_q;
        lo_fix = prod_s[WIDTH-1:0];
        hi_fix = '0;
        if (op_q == MLA) lo_fix = prod_q[WIDTH-1:0] + acc_q;
        if (is_long(op_q)) hi_fix = prod_s[2*WIDTH-1:WIDTH];
        if (is_long(op_q)) flags_fix = {hi_fix[WIDTH-1], ({hi_fix, lo_fix} == '0)};
        else               flags_fix = {lo_fix[WIDTH-1], (lo_fix == '0)};
    end

    // Control FSM; flush overrides everything, including a same-cycle start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= RUN;
                RUN:     if (last_iter) state <= FIX;
                FIX:     state <= DONE;
                DONE:    state <= accept ? RUN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand capture on accept, then one shift-add step per RUN cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= MUL;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            op_q     <= bus.op;
            acc_q    <= bus.acc;
            sign_q   <= (bus.op == SMULL) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
            mplier_q <= mag_b;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (state == RUN) begin
            prod_q   <= step_out;
            mcand_q  <= mcand_q << BPC;
            mplier_q <= mplier_nxt;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // Results change only on the edge entering DONE; an aborted op leaves them intact
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_lo  <= '0;
            res_hi  <= '0;
            flags_q <= '0;
        end else if (state == FIX && !bus.flush) begin
            res_lo  <= lo_fix;
            res_hi  <= hi_fix;
            flags_q <= flags_fix;
        end
    end

    assign bus.busy      = (state == RUN) || (state == FIX);
    assign bus.done      = (state == DONE);
    assign bus.result_lo = res_lo;
    assign bus.result_hi = res_hi;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: dut0 runs without early termination, dut1 with it.
// Expected results come from a 64-bit arithmetic model pushed to a scoreboard.
module tb_mul_unit;
    import mul_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [1:0]   flags;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mul_if #(.WIDTH(W)) bus0 ();
    mul_if #(.WIDTH(W)) bus1 ();

    mul_unit #(.WIDTH(W), .BPC(2), .EARLY_TERM(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mul_unit #(.WIDTH(W), .BPC(2), .EARLY_TERM(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    exp_t sb[$];
    exp_t last0;
    int passed = 0;
    int total  = 0;
    int dcnt0  = 0;
    int dcnt1  = 0;

    // done pulses seen per DUT (value before each edge)
    always @(posedge clk) begin
        if (bus0.done) dcnt0++;
        if (bus1.done) dcnt1++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input mul_op_t op, input logic [W-1:0] a, b, acc, input bit et);
        exp_t e;
        logic [63:0] p, sa, sbv;
        logic [W-1:0] mb;
        int it;
        sa  = {{W{a[W-1]}}, a};
        sbv = {{W{b[W-1]}}, b};
        case (op)
            MUL:     p = {32'b0, a * b};
            MLA:     p = {32'b0, a * b + acc};
            UMULL:   p = {32'b0, a} * {32'b0, b};
            default: p = sa * sbv;
        endcase
        e.lo = p[31:0];
        e.hi = p[63:32];
        if (op == UMULL || op == SMULL) e.flags = {p[63], (p == 64'd0)};
        else                            e.flags = {p[31], (p[31:0] == 32'd0)};
        mb = (op == SMULL && b[W-1]) ? -b : b;
        it = 1;
        while ((mb >> (2 * it)) != 0) it++;
        e.lat = et ? it + 2 : 18;
        return e;
    endfunction

    task automatic set_in(input int d, input logic st, input mul_op_t op, input logic [W-1:0] a, b, acc);
        if (d == 0) begin
            bus0.start = st; bus0.op = op; bus0.a = a; bus0.b = b; bus0.acc = acc;
        end else begin
            bus1.start = st; bus1.op = op; bus1.a = a; bus1.b = b; bus1.acc = acc;
        end
    endtask

    task automatic set_start(input int d, input logic st);
        if (d == 0) bus0.start = st; else bus1.start = st;
    endtask

    function automatic logic get_busy(input int d);
        return (d == 0) ? bus0.busy : bus1.busy;
    endfunction

    function automatic logic get_done(input int d);
        return (d == 0) ? bus0.done : bus1.done;
    endfunction

    function automatic logic [W-1:0] get_lo(input int d);
        return (d == 0) ? bus0.result_lo : bus1.result_lo;
    endfunction

    function automatic logic [W-1:0] get_hi(input int d);
        return (d == 0) ? bus0.result_hi : bus1.result_hi;
    endfunction

    function automatic logic [1:0] get_flags(input int d);
        return (d == 0) ? bus0.flags : bus1.flags;
    endfunction

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_lo"}, 64'(get_lo(d)), 64'd0);
        chk({tag, "_hi"}, 64'(get_hi(d)), 64'd0);
        chk({tag, "_ctl"}, 64'({get_busy(d), get_done(d), get_flags(d)}), 64'd0);
    endtask

    // Issue one op, wait (bounded) for done, compare against the scoreboard.
    // Latency counts the accepting edge as cycle 1.
    task automatic run_op(input int d, input mul_op_t op, input logic [W-1:0] a, b, acc,
                          input bit hold, input string tag);
        exp_t e, g;
        int k;
        bit seen;
        e = model(op, a, b, acc, d == 1);
        sb.push_back(e);
        if (d == 0) last0 = e;
        @(negedge clk);
        set_in(d, 1'b1, op, a, b, acc);
        @(posedge clk);
        k = 1;
        seen = 0;
        @(negedge clk);
        chk({tag, "_busy"}, 64'(get_busy(d)), 64'd1);
        for (int i = 0; i < 40; i++) begin
            if (i != 0) @(negedge clk);
            set_start(d, hold && get_busy(d));
            if (get_done(d)) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            k++;
        end
        set_start(d, 1'b0);
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            g = sb.pop_front();
            chk({tag, "_lat"}, 64'(k), 64'(g.lat));
            chk({tag, "_lo"}, 64'(get_lo(d)), 64'(g.lo));
            chk({tag, "_hi"}, 64'(get_hi(d)), 64'(g.hi));
            chk({tag, "_flags"}, 64'(get_flags(d)), 64'(g.flags));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, c1;
        bus0.flush = 1'b0;
        bus1.flush = 1'b0;
        set_in(0, 1'b0, MUL, '0, '0, '0);
        set_in(1, 1'b0, MUL, '0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");

        // Release reset between edges; the very next rising edge takes the start
        @(posedge clk);
        #1 reset = 1'b1;
        run_op(0, MUL,   32'd7,        32'd6,        32'd0, 0, "mul7x6");
        run_op(0, MLA,   32'hFFFFFFFF, 32'd2,        32'd5, 0, "mla_wrap");
        run_op(0, UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 0, "umull_max");
        run_op(0, MUL,   32'h00010000, 32'h00010000, 32'd0, 0, "mul_zero");
        run_op(0, SMULL, 32'hFFFFFFFF, 32'd1,        32'd0, 0, "smull_m1");

        c1 = dcnt1;
        run_op(1, UMULL, 32'd3, 32'd1, 32'd0, 1, "et_hold");
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("et_one_done", 64'(dcnt1 - c1), 64'd1);
        run_op(1, MUL,   32'd5,        32'd0,        32'd0,   0, "et_b0");
        run_op(1, UMULL, 32'h00010000, 32'h00010000, 32'd0,   0, "et_umull_z");
        run_op(1, SMULL, 32'h80000000, 32'h80000000, 32'd0,   0, "et_smull_min");
        run_op(1, SMULL, 32'h12345678, 32'hFFFFFFF0, 32'd0,   0, "et_smull_neg");
        run_op(1, MLA,   32'h0000BEEF, 32'h00000123, 32'd999, 0, "et_mla");

        // Abort on the 5th RUN cycle: no done, previous results kept
        @(negedge clk);
        set_in(0, 1'b1, MUL, 32'h0000FFFF, 32'hFFFFFFFF, 32'd0);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus0.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.flush = 1'b0;
        chk("flush_busy", 64'(bus0.busy), 64'd0);
        chk("flush_lo", 64'(bus0.result_lo), 64'(last0.lo));
        chk("flush_hi", 64'(bus0.result_hi), 64'(last0.hi));
        chk("flush_flags", 64'(bus0.flags), 64'(last0.flags));
        c0 = dcnt0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("flush_no_done", 64'(dcnt0 - c0), 64'd0);
        run_op(0, MUL, 32'd1000, 32'd1000, 32'd0, 0, "post_flush");

        // Reset in the middle of RUN clears everything without waiting for an edge
        @(negedge clk);
        set_in(0, 1'b1, UMULL, 32'hDEADBEEF, 32'hCAFEF00D, 32'd0);
        set_in(1, 1'b1, UMULL, 32'hDEADBEEF, 32'hCAFEF00D, 32'd0);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0);
        set_start(1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero(0, "midrst0");
        chk_zero(1, "midrst1");
        @(posedge clk);
        #1 reset = 1'b1;
        run_op(1, UMULL, 32'd123456, 32'd654321, 32'd0, 0, "post_rst");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
